// File: rtl/paralelo_serial_pkg.sv
// Shared constants for the parallel/serial link pair.
// Word width, fill word and FSM encoding live here so both ends agree.
package paralelo_serial_pkg;

    localparam int ANCHO = 10;
    localparam logic [ANCHO-1:0] COMA = 10'b0011111010;

    localparam logic [0:0] INACTIVO  = 1'b0;
    localparam logic [0:0] TRANSMITE = 1'b1;

    function automatic int ancho_contador(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/contador_mod10.sv
// Wrap-around bit counter, synchronous reset.
// Counts 0..MODULO-1 while enb is high and flags the last count.
module contador_mod10 #(
    parameter int MODULO = 10,
    parameter int W      = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enb,
    output logic [W-1:0] cuenta,
    output logic         fin
);

    localparam logic [W-1:0] TOPE = W'(MODULO - 1);

    assign fin = (cuenta == TOPE);

    always_ff @(posedge clk) begin
        if (rst) begin
            cuenta <= '0;
        end else if (enb) begin
            cuenta <= fin ? '0 : cuenta + 1'b1;
        end
    end

endmodule

// File: rtl/paralelo_serial.sv
// Parallel-to-serial transmitter, MSB first, one-word holding buffer.
// Idle slots are filled with the COMA word so the line never goes quiet.
module paralelo_serial #(
    parameter int ANCHO = paralelo_serial_pkg::ANCHO,
    parameter logic [ANCHO-1:0] COMA = paralelo_serial_pkg::COMA
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enb,
    input  logic [ANCHO-1:0] entradas,
    input  logic             validEntrada,
    output logic             listo,
    output logic             salida,
    output logic             inicioPalabra,
    output logic             esComa
);

    import paralelo_serial_pkg::*;

    localparam int CW = ancho_contador(ANCHO);

    logic [0:0]       estado;
    logic [ANCHO-1:0] retencion;
    logic [ANCHO-1:0] shift_reg;
    logic             lleno;
    logic             coma_q;
    logic [CW-1:0]    contador;
    logic             fin;
    logic             transmite;
    logic             cargar;
    logic             aceptar;

    assign transmite = (estado == TRANSMITE);
    // Reload either leaves idle or replaces the last bit, so words abut.
    assign cargar    = enb && (!transmite || fin);
    assign listo     = !rst && !lleno;
    assign aceptar   = validEntrada && listo && enb;

    contador_mod10 #(
        .MODULO(ANCHO),
        .W     (CW)
    ) u_contador (
        .clk   (clk),
        .rst   (rst),
        .enb   (enb && transmite),
        .cuenta(contador),
        .fin   (fin)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            estado    <= INACTIVO;
            lleno     <= 1'b0;
            coma_q    <= 1'b0;
            shift_reg <= '1;
            retencion <= '0;
        end else begin
            if (cargar) begin
                estado <= TRANSMITE;
                if (lleno) begin
                    shift_reg <= retencion;
                    lleno     <= 1'b0;
                    coma_q    <= 1'b0;
                end else begin
                    shift_reg <= COMA;
                    coma_q    <= 1'b1;
                end
            end else if (enb && transmite) begin
                shift_reg <= shift_reg << 1;
            end
            // aceptar implies !lleno, so it never races the reload clear
            if (aceptar) begin
                retencion <= entradas;
                lleno     <= 1'b1;
            end
        end
    end

    assign salida        = transmite ? shift_reg[ANCHO-1] : 1'b1;
    assign inicioPalabra = transmite && (contador == '0);
    assign esComa        = transmite && coma_q;

endmodule

// File: tb/tb_paralelo_serial.sv
// Scoreboard bench for paralelo_serial: driver queues expected words,
// monitor rebuilds each serial word and checks it against the queue.
module tb_paralelo_serial;

    logic       clk = 1'b0;
    logic       rst;
    logic       enb;
    logic [9:0] entradas;
    logic       validEntrada;
    logic       listo;
    logic       salida;
    logic       inicioPalabra;
    logic       esComa;

    typedef struct {
        logic [9:0] w;
        logic       coma;
    } exp_t;

    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    logic [9:0] coma_w = 10'b0011111010;
    logic [9:0] a_w    = 10'b1011001100;
    logic [9:0] c_w    = 10'b0011001100;
    logic [9:0] d_w    = 10'b1110001101;
    logic [9:0] f_w    = 10'b0101010101;

    bit         mon_on  = 1'b1;
    bit         mactive = 1'b0;
    int         mcnt    = 0;
    logic [9:0] acc;
    exp_t       cur;

    always #5 clk = ~clk;

    paralelo_serial dut (
        .clk          (clk),
        .rst          (rst),
        .enb          (enb),
        .entradas     (entradas),
        .validEntrada (validEntrada),
        .listo        (listo),
        .salida       (salida),
        .inicioPalabra(inicioPalabra),
        .esComa       (esComa)
    );

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic chkw(input string nm, input logic [9:0] act,
                        input logic [9:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic push(input logic [9:0] w, input logic coma);
        exp_t e;
        e.w    = w;
        e.coma = coma;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (!inicioPalabra && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk1(nm, n < 40, 1'b1);
    endtask

    // Monitor: a bit is consumed at the next rising edge only if enb is high.
    initial begin
        forever begin
            @(negedge clk);
            if (!mon_on) begin
                mactive = 1'b0;
            end else if (rst) begin
                mactive = 1'b0;
                mcnt    = 0;
            end else if (enb) begin
                if (mcnt == 0 && inicioPalabra) begin
                    acc = '0;
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL extra_word: got start, want none");
                        mactive = 1'b0;
                    end else begin
                        cur     = sb.pop_front();
                        mactive = 1'b1;
                    end
                end
                if (mactive) begin
                    if (mcnt != 0)
                        chk1("ini_mid", inicioPalabra, 1'b0);
                    chk1("esComa", esComa, cur.coma);
                    acc = {acc[8:0], salida};
                    mcnt++;
                    if (mcnt == 10) begin
                        chkw("word", acc, cur.w);
                        mcnt    = 0;
                        mactive = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        int lowc;
        int n;
        rst          = 1'b1;
        enb          = 1'b0;
        validEntrada = 1'b1;
        entradas     = 10'h3FF;

        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
            chk1("rst_salida", salida, 1'b1);
            chk1("rst_listo", listo, 1'b0);
            chk1("rst_coma", esComa, 1'b0);
            chk1("rst_ini", inicioPalabra, 1'b0);
        end

        tick();
        rst          = 1'b0;
        enb          = 1'b1;
        validEntrada = 1'b0;
        push(coma_w, 1'b1);
        push(coma_w, 1'b1);
        push(a_w, 1'b0);
        @(negedge clk);
        chk1("idle_listo", listo, 1'b1);
        chk1("idle_salida", salida, 1'b1);
        chk1("idle_ini", inicioPalabra, 1'b0);
        tick();

        // Offer A in the middle of the second COMA.
        repeat (12) tick();
        entradas     = a_w;
        validEntrada = 1'b1;
        tick();
        validEntrada = 1'b0;
        @(negedge clk);
        chk1("a_lleno", listo, 1'b0);

        // B then C held back to back while A goes out.
        wait_start("sync_a");
        tick();
        push(a_w, 1'b0);
        push(c_w, 1'b0);
        entradas     = a_w;
        validEntrada = 1'b1;
        tick();
        entradas = c_w;
        lowc = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (listo) break;
            lowc++;
            tick();
        end
        chkw("listo_low", 10'(lowc), 10'd8);
        chk1("listo_at_reload", inicioPalabra, 1'b1);
        tick();
        validEntrada = 1'b0;
        @(negedge clk);
        chk1("c_lleno", listo, 1'b0);

        // Freeze C for 5 cycles after 5 of its bits went out.
        wait_start("sync_c");
        repeat (5) tick();
        enb = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk1("frz_salida", salida, c_w[4]);
            chk1("frz_ini", inicioPalabra, 1'b0);
            chk1("frz_coma", esComa, 1'b0);
            tick();
        end
        enb = 1'b1;
        push(coma_w, 1'b1);

        // D goes out, F gets buffered, then reset while D is at bit 6.
        wait_start("sync_coma");
        tick();
        entradas     = d_w;
        validEntrada = 1'b1;
        tick();
        validEntrada = 1'b0;
        push(d_w, 1'b0);
        wait_start("sync_d");
        tick();
        entradas     = f_w;
        validEntrada = 1'b1;
        tick();
        validEntrada = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk1("pre_rst_salida", salida, d_w[6]);
        chk1("pre_rst_listo", listo, 1'b0);
        tick();
        @(negedge clk);
        chk1("mid_rst_salida", salida, 1'b1);
        chk1("mid_rst_ini", inicioPalabra, 1'b0);
        chk1("mid_rst_coma", esComa, 1'b0);
        chk1("mid_rst_listo", listo, 1'b0);
        tick();
        rst = 1'b0;
        push(coma_w, 1'b1);
        push(coma_w, 1'b1);
        @(negedge clk);
        chk1("post_rst_listo", listo, 1'b1);
        chk1("post_rst_salida", salida, 1'b1);

        n = 0;
        while (n < 60 && (sb.size() != 0 || mactive)) begin
            @(posedge clk);
            n++;
        end
        #1;
        mon_on = 1'b0;
        chk1("drain", n < 60, 1'b1);
        chkw("sb_left", 10'(sb.size()), 10'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

endmodule
